vect_unit_pipe: RTL

//  Parametrised, pipelined successor of the 4x8-bit vector unit: LANES independent LW-bit lanes per op.

---
 rtl/vect_unit_pipe.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vect_unit_pipe.sv
// Pipelined LANES x LW-bit SIMD ALU with optional unsigned saturation and per-lane carry flags.
// Two register stages (accept in cycle N -> out_valid in N+2); valid/ready backpressure holds both stages.
module vect_unit_pipe #(
    parameter int LANES = 4,
    parameter int LW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*LW-1:0]   operA,
    input  logic [LANES*LW-1:0]   operB,
    input  logic [3:0]            CtrlFunc,
    input  logic                  sat_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*LW-1:0]   result,
    output logic [LANES-1:0]      lane_carry,
    output logic [1:0]            flags
);
    localparam int W = LANES * LW;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MIN = 4'd8,
        OP_MAX = 4'd9
    } op_e;

    logic           s1_valid;
    logic [W-1:0]   s1_a;
    logic [W-1:0]   s1_b;
    logic [3:0]     s1_func;
    logic           s1_sat;
    logic           s2_valid;
    logic           s1_ready;
    logic           s2_ready;

    logic [W-1:0]     nxt_res;
    logic [LANES-1:0] nxt_lc;
    logic [LW-1:0]    lane_a;
    logic [LW-1:0]    lane_b;
    logic [LW:0]      lane_sum;
    logic [LW:0]      lane_dif;
    logic [LW-1:0]    lane_r;
    logic             lane_c;

    assign s2_ready  = !s2_valid || out_ready;
    assign s1_ready  = !s1_valid || s2_ready;
    assign in_ready  = s1_ready && !rst;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_func  <= '0;
            s1_sat   <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= operA;
                s1_b    <= operB;
                s1_func <= CtrlFunc;
                s1_sat  <= sat_en;
            end
        end
    end

    // Lane results are computed from the S1 registers and captured into S2.
    always_comb begin
        nxt_res  = '0;
        nxt_lc   = '0;
        lane_a   = '0;
        lane_b   = '0;
        lane_sum = '0;
        lane_dif = '0;
        lane_r   = '0;
        lane_c   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_a   = s1_a[i*LW +: LW];
            lane_b   = s1_b[i*LW +: LW];
            lane_sum = {1'b0, lane_a} + {1'b0, lane_b};
            lane_dif = {1'b0, lane_a} - {1'b0, lane_b};
            lane_r   = lane_a;
            lane_c   = 1'b0;
            case (s1_func)
                OP_ADD: begin
                    lane_c = lane_sum[LW];
                    lane_r = (s1_sat && lane_c) ? {LW{1'b1}} : lane_sum[LW-1:0];
                end
                OP_SUB: begin
                    lane_c = lane_dif[LW];
                    lane_r = (s1_sat && lane_c) ? {LW{1'b0}} : lane_dif[LW-1:0];
                end
                OP_AND: lane_r = lane_a & lane_b;
                OP_OR:  lane_r = lane_a | lane_b;
                OP_XOR: lane_r = lane_a ^ lane_b;
                OP_NOT: lane_r = ~lane_a;
                OP_SHL: begin
                    lane_r = {lane_a[LW-2:0], 1'b0};
                    lane_c = lane_a[LW-1];
                end
                OP_SHR: begin
                    lane_r = {1'b0, lane_a[LW-1:1]};
                    lane_c = lane_a[0];
                end
                OP_MIN: lane_r = (lane_a < lane_b) ? lane_a : lane_b;
                OP_MAX: lane_r = (lane_a > lane_b) ? lane_a : lane_b;
                default: lane_r = lane_a;
            endcase
            nxt_res[i*LW +: LW] = lane_r;
            nxt_lc[i]           = lane_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            result     <= '0;
            lane_carry <= '0;
            flags      <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result     <= nxt_res;
                lane_carry <= nxt_lc;
                flags      <= {(nxt_res == '0), |nxt_lc};
            end
        end
    end

endmodule
